// File: rtl/bm_calc_upd_p.sv
// bm_calc_upd_p: merges detector best-two SAD candidates with the stored best-two record.
// Optional last-pass uniqueness-ratio check is compiled in with `define BM_UNIQ_RATIO_EN.
module bm_calc_upd_p #(
  parameter int unsigned SAD_W   = 16,
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned PH_W    = 3,
  parameter int unsigned FRAC_W  = 8,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADJ     = 1,
  parameter int unsigned UNIQ_SH = 3,
  localparam int unsigned DISP_W = PH_W + IDX_W,
  localparam int unsigned REC_W  = 2*DISP_W + FRAC_W + 2*SAD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              first,
  input  logic              last,
  input  logic [PH_W-1:0]   dphase,
  input  logic [SAD_W-1:0]  det_min1,
  input  logic [SAD_W-1:0]  det_min2,
  input  logic [IDX_W-1:0]  det_idx1,
  input  logic [IDX_W-1:0]  det_idx2,
  input  logic              vin_m1,
  output logic [ADDR_W-1:0] sad_rdaddr,
  input  logic [REC_W-1:0]  sad_din,
  output logic              upd,
  output logic [SAD_W-1:0]  upd_min1,
  output logic [SAD_W-1:0]  upd_min2,
  output logic [DISP_W-1:0] upd_disp1,
  output logic [DISP_W-1:0] upd_disp2,
  output logic [FRAC_W-1:0] upd_frac,
  output logic [ADDR_W-1:0] upd_wraddr,
  output logic              uniq_fail,
  output logic              err_ovf,
  output logic              vout
);

  typedef struct packed {
    logic [DISP_W-1:0] disp1;
    logic [FRAC_W-1:0] frac;
    logic [SAD_W-1:0]  min1;
    logic [DISP_W-1:0] disp2;
    logic [SAD_W-1:0]  min2;
  } sad_rec_t;

  if (UNIQ_SH >= SAD_W || DEPTH > (1 << ADDR_W) || DEPTH == 0) begin : g_param_chk
    $error("bm_calc_upd_p: illegal parameter combination");
  end

  logic [ADDR_W-1:0] rdaddr_q, rdaddr_d, addr_r0_q, addr_r0_d, wraddr_q, wraddr_d;
  logic              err_ovf_q, err_ovf_d, vin_r0_q, vin_r0_d, vout_q, vout_d;
  logic              upd_q, upd_d, uniq_fail_q, uniq_fail_d;
  logic [SAD_W-1:0]  min1_q, min1_d, min2_q, min2_d;
  logic [DISP_W-1:0] disp1_q, disp1_d, disp2_q, disp2_d;
  logic [FRAC_W-1:0] frac_q, frac_d;

  sad_rec_t               sad_rec;
  logic [DISP_W-1:0]      det_disp1, det_disp2;
  logic signed [DISP_W:0] disp_diff;
  logic [DISP_W:0]        disp_dist;
  logic                   adj, lt11, lt21, lt12, lt22, mrg_upd;
  logic [SAD_W-1:0]       sec_min, mrg_min1, mrg_min2;
  logic [DISP_W-1:0]      sec_disp, mrg_disp1, mrg_disp2;

  // Best-two merge of detector and stored candidates with adjacency exclusion
  always_comb begin
    sad_rec   = sad_din;
    det_disp1 = {dphase, det_idx1};
    det_disp2 = {dphase, det_idx2};
    disp_diff = $signed({1'b0, det_disp1}) - $signed({1'b0, sad_rec.disp1});
    disp_dist = disp_diff[DISP_W] ? $unsigned(-disp_diff) : $unsigned(disp_diff);
    adj       = disp_dist <= (DISP_W+1)'(ADJ);
    lt11      = det_min1 < sad_rec.min1;
    lt21      = det_min2 < sad_rec.min1;
    lt12      = det_min1 < sad_rec.min2;
    lt22      = det_min2 < sad_rec.min2;
    sec_min   = lt22 ? det_min2  : sad_rec.min2;
    sec_disp  = lt22 ? det_disp2 : sad_rec.disp2;
    mrg_min1  = sad_rec.min1;
    mrg_disp1 = sad_rec.disp1;
    mrg_min2  = sad_rec.min2;
    mrg_disp2 = sad_rec.disp2;
    mrg_upd   = 1'b0;
    if (first || (lt11 && lt21)) begin
      mrg_min1  = det_min1;
      mrg_disp1 = det_disp1;
      mrg_min2  = det_min2;
      mrg_disp2 = det_disp2;
      mrg_upd   = 1'b1;
    end else if (lt11) begin
      mrg_min1  = det_min1;
      mrg_disp1 = det_disp1;
      mrg_min2  = adj ? sec_min  : sad_rec.min1;
      mrg_disp2 = adj ? sec_disp : sad_rec.disp1;
      mrg_upd   = 1'b1;
    end else if (lt12) begin
      mrg_min2  = adj ? sec_min  : det_min1;
      mrg_disp2 = adj ? sec_disp : det_disp1;
    end
  end

`ifdef BM_UNIQ_RATIO_EN
  logic [SAD_W:0] uniq_sum;
  assign uniq_sum = {1'b0, mrg_min1} + (SAD_W+1)'(mrg_min1 >> UNIQ_SH);
`else
  logic unused_last;
  assign unused_last = last;
`endif

  // Read-address counter, pipeline alignment and output stage
  always_comb begin
    rdaddr_d    = '0;
    err_ovf_d   = err_ovf_q;
    vin_r0_d    = vin_m1;
    addr_r0_d   = rdaddr_q;
    vout_d      = vin_r0_q;
    upd_d       = upd_q;
    min1_d      = min1_q;
    min2_d      = min2_q;
    disp1_d     = disp1_q;
    disp2_d     = disp2_q;
    frac_d      = frac_q;
    wraddr_d    = wraddr_q;
    uniq_fail_d = uniq_fail_q;
    if (vin_m1) begin
      if (rdaddr_q == ADDR_W'(DEPTH - 1)) err_ovf_d = 1'b1;
      else                                rdaddr_d  = rdaddr_q + ADDR_W'(1);
    end
    if (vin_r0_q) begin
      upd_d       = mrg_upd;
      min1_d      = mrg_min1;
      min2_d      = mrg_min2;
      disp1_d     = mrg_disp1;
      disp2_d     = mrg_disp2;
      frac_d      = mrg_upd ? '0 : sad_rec.frac;
      wraddr_d    = addr_r0_q;
      uniq_fail_d = 1'b0;
`ifdef BM_UNIQ_RATIO_EN
      if (last && !first && (uniq_sum >= {1'b0, mrg_min2})) begin
        disp1_d     = '1;
        upd_d       = 1'b0;
        uniq_fail_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdaddr_q    <= '0;
      err_ovf_q   <= 1'b0;
      vin_r0_q    <= 1'b0;
      addr_r0_q   <= '0;
      vout_q      <= 1'b0;
      upd_q       <= 1'b0;
      min1_q      <= '0;
      min2_q      <= '0;
      disp1_q     <= '0;
      disp2_q     <= '0;
      frac_q      <= '0;
      wraddr_q    <= '0;
      uniq_fail_q <= 1'b0;
    end else begin
      rdaddr_q    <= rdaddr_d;
      err_ovf_q   <= err_ovf_d;
      vin_r0_q    <= vin_r0_d;
      addr_r0_q   <= addr_r0_d;
      vout_q      <= vout_d;
      upd_q       <= upd_d;
      min1_q      <= min1_d;
      min2_q      <= min2_d;
      disp1_q     <= disp1_d;
      disp2_q     <= disp2_d;
      frac_q      <= frac_d;
      wraddr_q    <= wraddr_d;
      uniq_fail_q <= uniq_fail_d;
    end
  end

  assign sad_rdaddr = rdaddr_q;
  assign err_ovf    = err_ovf_q;
  assign vout       = vout_q;
  assign upd        = upd_q;
  assign upd_min1   = min1_q;
  assign upd_min2   = min2_q;
  assign upd_disp1  = disp1_q;
  assign upd_disp2  = disp2_q;
  assign upd_frac   = frac_q;
  assign upd_wraddr = wraddr_q;
  assign uniq_fail  = uniq_fail_q;

endmodule

// File: tb/tb_bm_calc_upd_p.sv
// Directed bench for bm_calc_upd_p (DEPTH reduced to 8 to reach the address wrap quickly).
`timescale 1ns/1ps
module tb_bm_calc_upd_p;

  logic        clk, rst, first, last, vin_m1;
  logic [2:0]  dphase;
  logic [15:0] det_min1, det_min2;
  logic [4:0]  det_idx1, det_idx2;
  logic [9:0]  sad_rdaddr, upd_wraddr;
  logic [55:0] sad_din;
  logic        upd, uniq_fail, err_ovf, vout;
  logic [15:0] upd_min1, upd_min2;
  logic [7:0]  upd_disp1, upd_disp2, upd_frac;

  int total = 0;
  int bad   = 0;

  bm_calc_upd_p #(
    .SAD_W(16), .IDX_W(5), .PH_W(3), .FRAC_W(8), .ADDR_W(10),
    .DEPTH(8), .ADJ(1), .UNIQ_SH(3)
  ) dut (
    .clk(clk), .rst(rst), .first(first), .last(last), .dphase(dphase),
    .det_min1(det_min1), .det_min2(det_min2), .det_idx1(det_idx1), .det_idx2(det_idx2),
    .vin_m1(vin_m1), .sad_rdaddr(sad_rdaddr), .sad_din(sad_din),
    .upd(upd), .upd_min1(upd_min1), .upd_min2(upd_min2),
    .upd_disp1(upd_disp1), .upd_disp2(upd_disp2), .upd_frac(upd_frac),
    .upd_wraddr(upd_wraddr), .uniq_fail(uniq_fail), .err_ovf(err_ovf), .vout(vout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [15:0] dm1, dm2;
    logic [4:0]  i1, i2;
    logic [7:0]  sd1;
    logic [15:0] sm1;
    logic [7:0]  sd2;
    logic [15:0] sm2;
    logic [15:0] em1;
    logic [7:0]  ed1;
    logic [15:0] em2;
    logic [7:0]  ed2;
    logic        eu;
    logic [7:0]  ef;
  } vec_t;

  vec_t mv [10];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [55:0] pack_sad(input logic [7:0] d1, input logic [7:0] fr,
                                           input logic [15:0] m1, input logic [7:0] d2,
                                           input logic [15:0] m2);
    return {d1, fr, m1, d2, m2};
  endfunction

  task automatic test_reset;
    total++; if (vout !== 1'b0) begin bad++; $display("FAIL rst_vout: got %0h want 0", vout); end
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL rst_upd: got %0h want 0", upd); end
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL rst_err_ovf: got %0h want 0", err_ovf); end
    total++; if (uniq_fail !== 1'b0) begin bad++; $display("FAIL rst_uniq: got %0h want 0", uniq_fail); end
    total++; if (sad_rdaddr !== 10'd0) begin bad++; $display("FAIL rst_rdaddr: got %0h want 0", sad_rdaddr); end
    total++; if (upd_wraddr !== 10'd0) begin bad++; $display("FAIL rst_wraddr: got %0h want 0", upd_wraddr); end
    total++;
    if ({upd_min1, upd_min2, upd_disp1, upd_disp2, upd_frac} !== 56'd0) begin
      bad++; $display("FAIL rst_data: got %0h want 0", {upd_min1, upd_min2, upd_disp1, upd_disp2, upd_frac});
    end
  endtask

  task automatic test_first_pass;
    first = 1'b1; last = 1'b0; dphase = 3'd2;
    det_min1 = 16'd100; det_idx1 = 5'd3; det_min2 = 16'd120; det_idx2 = 5'd9;
    sad_din = pack_sad(8'hAA, 8'h77, 16'd1, 8'hBB, 16'd2);
    for (int c = 0; c <= 5; c++) begin
      vin_m1 = (c < 4);
      if (c < 4) begin
        total++; if (sad_rdaddr !== 10'(c)) begin bad++; $display("FAIL first_rdaddr: got %0d want %0d", sad_rdaddr, c); end
      end
      tick;
      if (c == 0) begin
        total++; if (vout !== 1'b0) begin bad++; $display("FAIL first_latency: got vout=%0h want 0", vout); end
      end else if (c <= 4) begin
        total++; if (vout !== 1'b1) begin bad++; $display("FAIL first_vout: got %0h want 1", vout); end
        total++; if (upd_disp1 !== 8'h43) begin bad++; $display("FAIL first_disp1: got %0h want 43", upd_disp1); end
        total++; if (upd_disp2 !== 8'h49) begin bad++; $display("FAIL first_disp2: got %0h want 49", upd_disp2); end
        total++; if (upd_min1 !== 16'd100) begin bad++; $display("FAIL first_min1: got %0d want 100", upd_min1); end
        total++; if (upd_min2 !== 16'd120) begin bad++; $display("FAIL first_min2: got %0d want 120", upd_min2); end
        total++; if (upd !== 1'b1) begin bad++; $display("FAIL first_upd: got %0h want 1", upd); end
        total++; if (upd_frac !== 8'h00) begin bad++; $display("FAIL first_frac: got %0h want 0", upd_frac); end
        total++; if (upd_wraddr !== 10'(c - 1)) begin bad++; $display("FAIL first_wraddr: got %0d want %0d", upd_wraddr, c - 1); end
      end else begin
        total++; if (vout !== 1'b0) begin bad++; $display("FAIL first_vout_end: got %0h want 0", vout); end
        total++; if (upd_min1 !== 16'd100) begin bad++; $display("FAIL first_hold: got %0d want 100", upd_min1); end
        total++; if (sad_rdaddr !== 10'd0) begin bad++; $display("FAIL first_rdaddr_idle: got %0d want 0", sad_rdaddr); end
      end
    end
  endtask

  task automatic test_merge;
    //            dm1     dm2     i1    i2    sd1    sm1     sd2    sm2     em1     ed1    em2     ed2    eu    ef
    mv[0] = '{16'd40, 16'd70, 5'd1, 5'd8, 8'h20, 16'd50, 8'h30, 16'd80, 16'd40, 8'h21, 16'd70, 8'h28, 1'b1, 8'h00};
    mv[1] = '{16'd40, 16'd70, 5'd5, 5'd8, 8'h20, 16'd50, 8'h30, 16'd80, 16'd40, 8'h25, 16'd50, 8'h20, 1'b1, 8'h00};
    mv[2] = '{16'd50, 16'd70, 5'd1, 5'd8, 8'h20, 16'd50, 8'h30, 16'd80, 16'd50, 8'h20, 16'd70, 8'h28, 1'b0, 8'h5A};
    mv[3] = '{16'd30, 16'd45, 5'd2, 5'd3, 8'h20, 16'd50, 8'h30, 16'd80, 16'd30, 8'h22, 16'd45, 8'h23, 1'b1, 8'h00};
    mv[4] = '{16'd90, 16'd100, 5'd1, 5'd9, 8'h20, 16'd50, 8'h30, 16'd80, 16'd50, 8'h20, 16'd80, 8'h30, 1'b0, 8'h5A};
    mv[5] = '{16'd60, 16'd90, 5'd1, 5'd9, 8'h20, 16'd50, 8'h30, 16'd80, 16'd50, 8'h20, 16'd80, 8'h30, 1'b0, 8'h5A};
    mv[6] = '{16'd60, 16'd90, 5'd6, 5'd9, 8'h20, 16'd50, 8'h30, 16'd80, 16'd50, 8'h20, 16'd60, 8'h26, 1'b0, 8'h5A};
    mv[7] = '{16'd40, 16'd85, 5'd1, 5'd9, 8'h20, 16'd50, 8'h30, 16'd80, 16'd40, 8'h21, 16'd80, 8'h30, 1'b1, 8'h00};
    mv[8] = '{16'd40, 16'd70, 5'd1, 5'd8, 8'h22, 16'd50, 8'h30, 16'd80, 16'd40, 8'h21, 16'd70, 8'h28, 1'b1, 8'h00};
    mv[9] = '{16'd40, 16'd70, 5'd1, 5'd8, 8'h23, 16'd50, 8'h30, 16'd80, 16'd40, 8'h21, 16'd50, 8'h23, 1'b1, 8'h00};
    first = 1'b0; last = 1'b0; dphase = 3'd1;
    for (int i = 0; i < 10; i++) begin
      vin_m1 = 1'b1;
      tick;
      vin_m1 = 1'b0;
      det_min1 = mv[i].dm1; det_min2 = mv[i].dm2; det_idx1 = mv[i].i1; det_idx2 = mv[i].i2;
      sad_din = pack_sad(mv[i].sd1, 8'h5A, mv[i].sm1, mv[i].sd2, mv[i].sm2);
      tick;
      total++; if (vout !== 1'b1) begin bad++; $display("FAIL merge%0d_vout: got %0h want 1", i, vout); end
      total++; if (upd_min1 !== mv[i].em1) begin bad++; $display("FAIL merge%0d_min1: got %0d want %0d", i, upd_min1, mv[i].em1); end
      total++; if (upd_disp1 !== mv[i].ed1) begin bad++; $display("FAIL merge%0d_disp1: got %0h want %0h", i, upd_disp1, mv[i].ed1); end
      total++; if (upd_min2 !== mv[i].em2) begin bad++; $display("FAIL merge%0d_min2: got %0d want %0d", i, upd_min2, mv[i].em2); end
      total++; if (upd_disp2 !== mv[i].ed2) begin bad++; $display("FAIL merge%0d_disp2: got %0h want %0h", i, upd_disp2, mv[i].ed2); end
      total++; if (upd !== mv[i].eu) begin bad++; $display("FAIL merge%0d_upd: got %0h want %0h", i, upd, mv[i].eu); end
      total++; if (upd_frac !== mv[i].ef) begin bad++; $display("FAIL merge%0d_frac: got %0h want %0h", i, upd_frac, mv[i].ef); end
    end
  endtask

  task automatic test_uniq;
    logic [15:0] dm2_t [3];
    logic        first_t [3];
    logic [7:0]  exp_d1 [3];
    logic        exp_upd [3];
    logic        exp_uf [3];
    dm2_t   = '{16'd85, 16'd95, 16'd85};
    first_t = '{1'b0, 1'b0, 1'b1};
`ifdef BM_UNIQ_RATIO_EN
    exp_d1  = '{8'hFF, 8'h23, 8'h23};
    exp_upd = '{1'b0, 1'b1, 1'b1};
    exp_uf  = '{1'b1, 1'b0, 1'b0};
`else
    exp_d1  = '{8'h23, 8'h23, 8'h23};
    exp_upd = '{1'b1, 1'b1, 1'b1};
    exp_uf  = '{1'b0, 1'b0, 1'b0};
`endif
    last = 1'b1; dphase = 3'd1;
    for (int i = 0; i < 3; i++) begin
      first = first_t[i];
      vin_m1 = 1'b1;
      tick;
      vin_m1 = 1'b0;
      det_min1 = 16'd80; det_idx1 = 5'd3; det_min2 = dm2_t[i]; det_idx2 = 5'd4;
      sad_din = pack_sad(8'h10, 8'h11, 16'd200, 8'h30, 16'd300);
      tick;
      total++; if (upd_min1 !== 16'd80) begin bad++; $display("FAIL uniq%0d_min1: got %0d want 80", i, upd_min1); end
      total++; if (upd_min2 !== dm2_t[i]) begin bad++; $display("FAIL uniq%0d_min2: got %0d want %0d", i, upd_min2, dm2_t[i]); end
      total++; if (upd_disp1 !== exp_d1[i]) begin bad++; $display("FAIL uniq%0d_disp1: got %0h want %0h", i, upd_disp1, exp_d1[i]); end
      total++; if (upd !== exp_upd[i]) begin bad++; $display("FAIL uniq%0d_upd: got %0h want %0h", i, upd, exp_upd[i]); end
      total++; if (uniq_fail !== exp_uf[i]) begin bad++; $display("FAIL uniq%0d_flag: got %0h want %0h", i, uniq_fail, exp_uf[i]); end
    end
    last = 1'b0;
  endtask

  task automatic test_overflow;
    first = 1'b1; last = 1'b0; dphase = 3'd0;
    det_min1 = 16'd5; det_idx1 = 5'd1; det_min2 = 16'd6; det_idx2 = 5'd2;
    for (int c = 0; c <= 11; c++) begin
      vin_m1 = (c < 10);
      if (c < 10) begin
        total++; if (sad_rdaddr !== 10'(c % 8)) begin bad++; $display("FAIL ovf_rdaddr%0d: got %0d want %0d", c, sad_rdaddr, c % 8); end
        total++; if (err_ovf !== (c >= 8)) begin bad++; $display("FAIL ovf_flag%0d: got %0h want %0h", c, err_ovf, (c >= 8)); end
      end
      tick;
      if (c >= 1 && c <= 10) begin
        total++; if (upd_wraddr !== 10'((c - 1) % 8)) begin bad++; $display("FAIL ovf_wraddr%0d: got %0d want %0d", c, upd_wraddr, (c - 1) % 8); end
      end
    end
    total++; if (sad_rdaddr !== 10'd0) begin bad++; $display("FAIL ovf_rdaddr_idle: got %0d want 0", sad_rdaddr); end
    total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0h want 1", err_ovf); end
  endtask

  task automatic test_reset_mid_burst;
    first = 1'b1; dphase = 3'd2;
    det_min1 = 16'd100; det_idx1 = 5'd3; det_min2 = 16'd120; det_idx2 = 5'd9;
    vin_m1 = 1'b1;
    tick; tick; tick;
    #2;
    rst = 1'b1;
    #1;
    test_reset;
    vin_m1 = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    for (int c = 0; c <= 3; c++) begin
      vin_m1 = (c < 3);
      if (c < 3) begin
        total++; if (sad_rdaddr !== 10'(c)) begin bad++; $display("FAIL rb_rdaddr: got %0d want %0d", sad_rdaddr, c); end
      end
      tick;
      if (c == 0) begin
        total++; if (vout !== 1'b0) begin bad++; $display("FAIL rb_latency: got vout=%0h want 0", vout); end
      end else begin
        total++; if (vout !== 1'b1) begin bad++; $display("FAIL rb_vout: got %0h want 1", vout); end
        total++; if (upd_wraddr !== 10'(c - 1)) begin bad++; $display("FAIL rb_wraddr: got %0d want %0d", upd_wraddr, c - 1); end
        total++; if (upd_disp1 !== 8'h43) begin bad++; $display("FAIL rb_disp1: got %0h want 43", upd_disp1); end
      end
    end
    vin_m1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; first = 1'b0; last = 1'b0; vin_m1 = 1'b0; dphase = '0;
    det_min1 = '0; det_min2 = '0; det_idx1 = '0; det_idx2 = '0; sad_din = '0;
    tick; tick;
    test_reset;
    rst = 1'b0;
    tick;
    test_first_pass;
    test_merge;
    test_uniq;
    tick;
    test_overflow;
    test_reset_mid_burst;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
